// File: rtl/freq_meas_pkg.sv
// Shared types and helpers for the frequency/period measurement blocks.
package freq_meas_pkg;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  // Result layout of f_log2_pow2: bit 6 is the power-of-two flag,
  // bits 5:0 are the index of the single set bit (0 when not a power of two).
  localparam int unsigned POW2_RES_W = 7;

  function automatic logic [POW2_RES_W-1:0] f_log2_pow2(input logic [31:0] value);
    logic       isPow2;
    logic [5:0] idx;
    isPow2 = (value != '0) && ((value & (value - 32'd1)) == '0);
    idx    = '0;
    if (isPow2) begin
      for (int unsigned i = 0; i < 32; i++) begin
        if (value[i]) idx = 6'(i);
      end
    end
    return {isPow2, idx};
  endfunction

endpackage

// File: rtl/freq_ratio_meter_rise_detect.sv
// Rising-edge detector for a signal already synchronous to clk.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic dQ;

  // Previous-sample register; resets high so a level that is already high
  // at reset release is not mistaken for an edge.
  always_ff @(posedge clk) begin
    if (rst) dQ <= 1'b1;
    else     dQ <= d;
  end

  assign rise = d & ~dQ;

endmodule

// File: rtl/freq_ratio_meter.sv
// Measures period and high time of sig_in, classifies power-of-two ratios
// and reports lock once consecutive measurements agree.
module freq_ratio_meter
  import freq_meas_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sig_in,
  output logic [CNT_W-1:0]        period,
  output logic [CNT_W-1:0]        high_time,
  output logic                    meas_valid,
  output logic                    is_pow2,
  output logic [$clog2(CNT_W):0]  log2_ratio,
  output logic                    locked,
  output logic                    overflow
);

  localparam int unsigned LOG_W = $clog2(CNT_W) + 1;
  localparam int unsigned LK_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [LK_W-1:0] LK_MAX = LK_W'(LOCK_COUNT);

  state_t                  state, stateNext;
  logic                    rise;
  logic [CNT_W-1:0]        cnt, hcnt;
  logic [LK_W-1:0]         lk, lkNext;
  logic                    doLoad, doCapture, doOverflow;
  logic                    sameMeas;
  logic [POW2_RES_W-1:0]   pow2Res;

  rise_detect uRise (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .rise (rise)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state and datapath controls; a rise at cnt=all-ones wins over overflow.
  always_comb begin
    stateNext  = state;
    doLoad     = 1'b0;
    doCapture  = 1'b0;
    doOverflow = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          doLoad    = 1'b1;
          stateNext = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          doCapture = 1'b1;
        end else if (cnt == '1) begin
          doOverflow = 1'b1;
          stateNext  = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Lock bookkeeping; lk==0 marks "no previous capture since reset/overflow".
  always_comb begin
    pow2Res  = f_log2_pow2(32'(cnt));
    sameMeas = (cnt == period) && (hcnt == high_time);
    lkNext   = LK_W'(1);
    if ((lk != '0) && sameMeas) begin
      lkNext = (lk == LK_MAX) ? lk : lk + LK_W'(1);
    end
  end

  // Counters, captured measurement, classification and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      hcnt       <= '0;
      lk         <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      is_pow2    <= 1'b0;
      log2_ratio <= '0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      meas_valid <= doCapture;
      if (doLoad || doCapture) begin
        cnt  <= CNT_W'(1);
        hcnt <= CNT_W'(1);
      end else if ((state == MEASURE) && !doOverflow) begin
        cnt  <= cnt + CNT_W'(1);
        hcnt <= hcnt + CNT_W'(sig_in);
      end
      if (doCapture) begin
        period     <= cnt;
        high_time  <= hcnt;
        is_pow2    <= pow2Res[POW2_RES_W-1];
        log2_ratio <= LOG_W'(pow2Res[POW2_RES_W-2:0]);
        overflow   <= 1'b0;
        lk         <= lkNext;
        locked     <= (lkNext == LK_MAX);
      end
      if (doOverflow) begin
        overflow <= 1'b1;
        lk       <= '0;
        locked   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_freq_ratio_meter.sv
// Directed self-checking bench for freq_ratio_meter (CNT_W=8, LOCK_COUNT=4).
module tb_freq_ratio_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sigIn = 1'b0;
  logic [7:0] period, highTime;
  logic       measValid, isPow2, locked, overflow;
  logic [3:0] log2Ratio;

  int total = 0;
  int bad   = 0;

  // Snapshot of the last meas_valid seen by drivePeriod.
  int         sPulses, sIdx;
  logic [7:0] sPeriod, sHigh;
  logic       sPow2, sLocked, sOvf;
  logic [3:0] sLog;

  freq_ratio_meter #(.CNT_W(8), .LOCK_COUNT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sigIn),
    .period     (period),
    .high_time  (highTime),
    .meas_valid (measValid),
    .is_pow2    (isPow2),
    .log2_ratio (log2Ratio),
    .locked     (locked),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v);
    sigIn = v;
    @(posedge clk);
    #1;
  endtask

  // One signal period: hi cycles high (rise on the first) then lo cycles low.
  task automatic drivePeriod(input int hi, input int lo);
    sPulses = 0;
    sIdx    = -1;
    for (int i = 0; i < hi + lo; i++) begin
      step(i < hi);
      if (measValid) begin
        sPulses++;
        sIdx    = i;
        sPeriod = period;
        sHigh   = highTime;
        sPow2   = isPow2;
        sLog    = log2Ratio;
        sLocked = locked;
        sOvf    = overflow;
      end
    end
  endtask

  task automatic doReset(input logic lvl);
    rst = 1'b1;
    step(lvl);
    step(lvl);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    doReset(1'b0);
    step(1'b0);
    total++; if (period !== 8'd0) begin bad++; $display("FAIL reset_period got=%0d exp=0", period); end
    total++; if (highTime !== 8'd0) begin bad++; $display("FAIL reset_high got=%0d exp=0", highTime); end
    total++; if ({measValid, isPow2, locked, overflow} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {measValid, isPow2, locked, overflow}); end
    total++; if (log2Ratio !== 4'd0) begin bad++; $display("FAIL reset_log2 got=%0d exp=0", log2Ratio); end
  endtask

  task automatic test_div2;
    doReset(1'b0);
    step(1'b0);
    for (int c = 1; c <= 6; c++) begin
      drivePeriod(1, 1);
      total++; if (sPulses !== ((c >= 2) ? 1 : 0)) begin bad++; $display("FAIL div2_pulses call=%0d got=%0d exp=%0d", c, sPulses, (c >= 2) ? 1 : 0); end
      if (c >= 2) begin
        total++; if (sPeriod !== 8'd2) begin bad++; $display("FAIL div2_period call=%0d got=%0d exp=2", c, sPeriod); end
        total++; if (sHigh !== 8'd1) begin bad++; $display("FAIL div2_high call=%0d got=%0d exp=1", c, sHigh); end
        total++; if ({sPow2, sLog} !== {1'b1, 4'd1}) begin bad++; $display("FAIL div2_class call=%0d got=%b/%0d exp=1/1", c, sPow2, sLog); end
        total++; if (sLocked !== (c >= 5)) begin bad++; $display("FAIL div2_locked call=%0d got=%b exp=%b", c, sLocked, c >= 5); end
      end
    end
  endtask

  task automatic test_div32;
    doReset(1'b0);
    step(1'b0);
    for (int c = 1; c <= 3; c++) begin
      drivePeriod(16, 16);
      total++; if (sPulses !== ((c >= 2) ? 1 : 0)) begin bad++; $display("FAIL div32_pulses call=%0d got=%0d exp=%0d", c, sPulses, (c >= 2) ? 1 : 0); end
      if (c >= 2) begin
        total++; if (sIdx !== 0) begin bad++; $display("FAIL div32_latency call=%0d got=%0d exp=0", c, sIdx); end
        total++; if (sPeriod !== 8'd32) begin bad++; $display("FAIL div32_period call=%0d got=%0d exp=32", c, sPeriod); end
        total++; if (sHigh !== 8'd16) begin bad++; $display("FAIL div32_high call=%0d got=%0d exp=16", c, sHigh); end
        total++; if ({sPow2, sLog} !== {1'b1, 4'd5}) begin bad++; $display("FAIL div32_class call=%0d got=%b/%0d exp=1/5", c, sPow2, sLog); end
      end
    end
  endtask

  task automatic test_nonpow2;
    doReset(1'b0);
    step(1'b0);
    for (int c = 1; c <= 5; c++) begin
      drivePeriod(4, 2);
      if (c >= 2) begin
        total++; if (sPeriod !== 8'd6) begin bad++; $display("FAIL np2_period call=%0d got=%0d exp=6", c, sPeriod); end
        total++; if (sHigh !== 8'd4) begin bad++; $display("FAIL np2_high call=%0d got=%0d exp=4", c, sHigh); end
        total++; if ({sPow2, sLog} !== {1'b0, 4'd0}) begin bad++; $display("FAIL np2_class call=%0d got=%b/%0d exp=0/0", c, sPow2, sLog); end
        total++; if (sLocked !== (c == 5)) begin bad++; $display("FAIL np2_locked call=%0d got=%b exp=%b", c, sLocked, c == 5); end
      end
    end
    // Switch duty: first capture still sees the old 4-high period.
    for (int c = 1; c <= 5; c++) begin
      drivePeriod(3, 3);
      total++; if (sHigh !== ((c == 1) ? 8'd4 : 8'd3)) begin bad++; $display("FAIL duty_high call=%0d got=%0d exp=%0d", c, sHigh, (c == 1) ? 4 : 3); end
      total++; if (sLocked !== (c == 1 || c == 5)) begin bad++; $display("FAIL duty_locked call=%0d got=%b exp=%b", c, sLocked, c == 1 || c == 5); end
    end
  endtask

  // Runs straight after test_nonpow2, while locked at period 6 / high 3.
  task automatic test_stuck;
    int firstOvf;
    int pulses;
    firstOvf = -1;
    pulses   = 0;
    for (int s = 1; s <= 300; s++) begin
      step(1'b0);
      if (measValid) pulses++;
      if (overflow && firstOvf < 0) firstOvf = s;
    end
    total++; if (firstOvf !== 250) begin bad++; $display("FAIL stuck_ovf_time got=%0d exp=250", firstOvf); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL stuck_pulses got=%0d exp=0", pulses); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL stuck_locked got=%b exp=0", locked); end
    total++; if ({period, highTime} !== {8'd6, 8'd3}) begin bad++; $display("FAIL stuck_held got=%0d/%0d exp=6/3", period, highTime); end
    drivePeriod(1, 1);
    total++; if ({sPulses, overflow} !== {32'd0, 1'b1}) begin bad++; $display("FAIL restart_first got=%0d/%b exp=0/1", sPulses, overflow); end
    drivePeriod(1, 1);
    total++; if (sPulses !== 1) begin bad++; $display("FAIL restart_pulses got=%0d exp=1", sPulses); end
    total++; if ({sOvf, sLocked} !== 2'b00) begin bad++; $display("FAIL restart_flags got=%b exp=00", {sOvf, sLocked}); end
    total++; if (sPeriod !== 8'd2) begin bad++; $display("FAIL restart_period got=%0d exp=2", sPeriod); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    doReset(1'b0);
    step(1'b0);
    for (int c = 1; c <= 3; c++) drivePeriod(4, 2);
    step(1'b1);
    step(1'b1);
    doReset(1'b1);
    total++; if ({period, highTime, log2Ratio} !== 20'd0) begin bad++; $display("FAIL rmid_values got=%0d/%0d/%0d exp=0/0/0", period, highTime, log2Ratio); end
    total++; if ({measValid, isPow2, locked, overflow} !== 4'b0000) begin bad++; $display("FAIL rmid_flags got=%b exp=0000", {measValid, isPow2, locked, overflow}); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      if (measValid) pulses++;
    end
    step(1'b0);
    if (measValid) pulses++;
    drivePeriod(2, 2);
    total++; if (pulses + sPulses !== 0) begin bad++; $display("FAIL rmid_no_edge got=%0d exp=0", pulses + sPulses); end
    drivePeriod(2, 2);
    total++; if (sPulses !== 1) begin bad++; $display("FAIL rmid_pulses got=%0d exp=1", sPulses); end
    total++; if ({sPeriod, sHigh} !== {8'd4, 8'd2}) begin bad++; $display("FAIL rmid_meas got=%0d/%0d exp=4/2", sPeriod, sHigh); end
    total++; if ({sPow2, sLog, sLocked} !== {1'b1, 4'd2, 1'b0}) begin bad++; $display("FAIL rmid_class got=%b/%0d/%b exp=1/2/0", sPow2, sLog, sLocked); end
  endtask

  task automatic test_boundary;
    doReset(1'b0);
    step(1'b0);
    for (int c = 1; c <= 3; c++) begin
      drivePeriod(1, 254);
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bound_ovf call=%0d got=%b exp=0", c, overflow); end
      if (c >= 2) begin
        total++; if (sPulses !== 1) begin bad++; $display("FAIL bound_pulses call=%0d got=%0d exp=1", c, sPulses); end
        total++; if ({sPeriod, sHigh} !== {8'd255, 8'd1}) begin bad++; $display("FAIL bound_meas call=%0d got=%0d/%0d exp=255/1", c, sPeriod, sHigh); end
        total++; if ({sOvf, sPow2, sLocked} !== 3'b000) begin bad++; $display("FAIL bound_flags call=%0d got=%b exp=000", c, {sOvf, sPow2, sLocked}); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_div2;
    test_div32;
    test_nonpow2;
    test_stuck;
    test_reset_mid;
    test_boundary;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
